// File: rtl/split_port_arbiter.sv
// split_port_arbiter: shares one backing-memory port between an instruction port (A) and a data port (B)
// Ports: clk/rst_n (async active-low); port A read request (read_a, address_a -> resp_a, rdata_a);
// port B read/write request (read_b, write, wmask, address_b, wdata -> resp_b, rdata_b);
// backing memory (pmem_read, pmem_write, pmem_wmask, pmem_address, pmem_wdata <- pmem_resp, pmem_rdata);
// timeout_err is sticky once any backing access exceeds MAX_WAIT cycles.
// Option: define ARB_ROUND_ROBIN_EN to alternate grants when both ports request (B first after reset);
// otherwise port B always wins.
module split_port_arbiter #(
  parameter int MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        read_a,
  input  logic [31:0] address_a,
  output logic        resp_a,
  output logic [31:0] rdata_a,
  input  logic        read_b,
  input  logic        write,
  input  logic [3:0]  wmask,
  input  logic [31:0] address_b,
  input  logic [31:0] wdata,
  output logic        resp_b,
  output logic [31:0] rdata_b,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [3:0]  pmem_wmask,
  output logic [31:0] pmem_address,
  output logic [31:0] pmem_wdata,
  input  logic        pmem_resp,
  input  logic [31:0] pmem_rdata,
  output logic        timeout_err
);
  typedef enum logic [2:0] {IDLE, SERVE_A, SERVE_B, DONE_A, DONE_B} state_t;
  state_t state, state_nx;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  wmask_q;
  logic        wr_q, req_b, grant_b, serving, finish, timeout, launch;
  logic [15:0] cnt;
  assign req_b = read_b | write;
`ifdef ARB_ROUND_ROBIN_EN
  logic last_b;
  // when both ports request, yield to whichever was not served last
  assign grant_b = req_b & (~read_a | ~last_b);
`else
  assign grant_b = req_b;
`endif
  assign serving = (state == SERVE_A) || (state == SERVE_B);
  // reaching MAX_WAIT with a response in the same cycle still counts as success
  assign timeout = serving & ~pmem_resp & (cnt == 16'(MAX_WAIT - 1));
  assign finish  = serving & (pmem_resp | timeout);
  assign launch  = (state == IDLE) && (state_nx != IDLE);
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = grant_b ? SERVE_B : (read_a ? SERVE_A : IDLE);
      SERVE_A: state_nx = finish ? DONE_A : SERVE_A;
      SERVE_B: state_nx = finish ? DONE_B : SERVE_B;
      default: state_nx = IDLE;
    endcase
  end
  assign resp_a       = state == DONE_A;
  assign resp_b       = state == DONE_B;
  assign pmem_read    = (state == SERVE_A) || ((state == SERVE_B) && !wr_q);
  assign pmem_write   = (state == SERVE_B) && wr_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;
  assign pmem_wmask   = wmask_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      wr_q        <= 1'b0;
      rdata_a     <= '0;
      rdata_b     <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_nx;
      // every SERVE is entered from IDLE, so clearing in IDLE starts each wait at zero
      cnt <= (state == IDLE) ? '0 : (serving && !pmem_resp) ? cnt + 16'd1 : cnt;
      if (launch) begin
        addr_q  <= grant_b ? address_b : address_a;
        wdata_q <= wdata;
        wmask_q <= wmask;
        wr_q    <= grant_b & write;
      end
      if (finish && state == SERVE_A) rdata_a <= pmem_resp ? pmem_rdata : '0;
      // writes leave rdata_b untouched, including on timeout
      if (finish && state == SERVE_B && !wr_q) rdata_b <= pmem_resp ? pmem_rdata : '0;
      if (timeout) timeout_err <= 1'b1;
    end
  end
`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_b <= 1'b0;
    else if (launch) last_b <= grant_b;
  end
`endif
endmodule
